// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits answer combinationally; misses refill a 4-word line in order, writes go out as single beats.
module dcache_ctrl #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic [29:0] core_addr_i,
    input  logic [3:0]  core_wen_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        busy_o,
    input  logic        invalidate_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int IDX  = $clog2(LINES);
    localparam int OFFW = $clog2(WORDS_PER_LINE);
    localparam int TAGW = 30 - IDX - OFFW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OFFW-1:0]     beat_q, beat_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                pend_q, pend_d;
    logic [TAGW-1:0]     tag_q  [LINES];
    logic [31:0]         data_q [LINES*WORDS_PER_LINE];

    logic [OFFW-1:0]     off_s;
    logic [IDX-1:0]      idx_s;
    logic [TAGW-1:0]     tag_s;
    logic                line_hit_s;
    logic                hit_s;
    logic                last_beat_s;
    logic [31:0]         rd_word_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    assign off_s       = core_addr_i[OFFW-1:0];
    assign idx_s       = core_addr_i[IDX+OFFW-1:OFFW];
    assign tag_s       = core_addr_i[29:IDX+OFFW];
    assign line_hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign hit_s       = core_req_i && (core_wen_i == 4'b0000) && line_hit_s;
    assign last_beat_s = (beat_q == {OFFW{1'b1}});
    assign rd_word_s   = data_q[{idx_s, off_s}];

    // State, beat counter, valid bits and pending-invalidate flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= {OFFW{1'b0}};
            valid_q <= {LINES{1'b0}};
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    // Tag and data arrays: refill beats and write-hit byte merges; not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && (state_q == S_REFILL) && mem_ack_i) begin
            data_q[{idx_s, beat_q}] <= mem_rdata_i;
            if (last_beat_s) begin
                tag_q[idx_s] <= tag_s;
            end
        end
        if (rst_i && (state_q == S_WRITE) && mem_ack_i && line_hit_s) begin
            data_q[{idx_s, off_s}] <= merge_bytes(rd_word_s, core_wdata_i, core_wen_i);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                beat_d = {OFFW{1'b0}};
                pend_d = 1'b0;
                if (invalidate_i) begin
                    valid_d = {LINES{1'b0}};
                end else begin
                    valid_d = valid_q;
                end
                if (!core_req_i) begin
                    state_d = S_IDLE;
                end else if (core_wen_i != 4'b0000) begin
                    state_d = S_WRITE;
                end else if (!hit_s) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REFILL: begin
                pend_d = pend_q | invalidate_i;
                if (mem_ack_i) begin
                    beat_d = beat_q + OFFW'(1);
                    if (last_beat_s) begin
                        valid_d[idx_s] = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_REFILL;
                    end
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITE: begin
                pend_d = pend_q | invalidate_i;
                if (mem_ack_i) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
                // A pending invalidate wins over the valid bit just set by the refill.
                if (invalidate_i || pend_q) begin
                    valid_d = {LINES{1'b0}};
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = {OFFW{1'b0}};
                pend_d  = 1'b0;
            end
        endcase
    end

    // Output decode for core and memory sides.
    always_comb begin
        core_rdata_o = 32'h0000_0000;
        busy_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 30'h0000_0000;
        mem_wstrb_o  = 4'b0000;
        mem_wdata_o  = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                busy_o = core_req_i && !hit_s;
                if (hit_s) begin
                    core_rdata_o = rd_word_s;
                end else begin
                    core_rdata_o = 32'h0000_0000;
                end
            end
            S_REFILL: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {core_addr_i[29:OFFW], beat_q};
            end
            S_WRITE: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = core_addr_i;
                mem_wstrb_o = core_wen_i;
                mem_wdata_o = core_wdata_i;
            end
            S_RESP: begin
                core_rdata_o = rd_word_s;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// against a line-presence model and a backing-memory model.
module tb_dcache_ctrl;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic [29:0] core_addr;
    logic [3:0]  core_wen;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        busy;
    logic        invalidate;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] last_rd;

    // Backing store (sparse) and which line address each index currently caches.
    bit [31:0] mem_m [bit [29:0]];
    bit        m_vld  [LINES];
    bit [27:0] m_line [LINES];

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(LINES), .WORDS_PER_LINE(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .core_req_i  (core_req),
        .core_addr_i (core_addr),
        .core_wen_i  (core_wen),
        .core_wdata_i(core_wdata),
        .core_rdata_o(core_rdata),
        .busy_o      (busy),
        .invalidate_i(invalidate),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wstrb_o (mem_wstrb),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    function automatic bit [31:0] mem_val(input bit [29:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
    endtask

    // One core access. Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
    // inv_mode: 0 none, 1 invalidate with the request in IDLE, 2 invalidate during bus phase.
    // rst_beat: nonzero -> reset after that many refill acks.
    task automatic access(input bit [29:0] a, input bit [3:0] wen, input bit [31:0] wd,
                          input int dly, input int inv_mode, input int rst_beat);
        bit        is_wr   = (wen != 4'b0000);
        bit [5:0]  idx     = a[7:2];
        bit [27:0] line    = a[29:2];
        bit        exp_hit = !is_wr && m_vld[idx] && (m_line[idx] == line);
        int        nbeats  = is_wr ? 1 : 4;
        bit [1:0]  bb;
        bit [31:0] nv;
        core_req   = 1'b1;
        core_addr  = a;
        core_wen   = wen;
        core_wdata = wd;
        invalidate = (inv_mode == 1);
        @(negedge clk);
        chk("busy_first_cycle", 32'(busy), 32'(!exp_hit));
        chk("no_bus_in_idle", 32'(mem_req), 32'd0);
        if (exp_hit) begin
            chk("hit_data", core_rdata, mem_val(a));
            last_rd = core_rdata;
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        mem_ack    = 1'b0;
        invalidate = 1'b0;
        if (inv_mode == 1) clear_model();
        if (exp_hit) begin
            core_req = 1'b0;
            return;
        end
        for (int b = 0; b < nbeats; b++) begin
            bb = b[1:0];
            for (int d = 0; d <= dly; d++) begin
                if (rst_beat != 0 && b == rst_beat && d == 0) begin
                    rst_n    = 1'b0;
                    core_req = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("rst_mid_req", 32'(mem_req), 32'd0);
                    chk("rst_mid_busy", 32'(busy), 32'd0);
                    clear_model();
                    @(posedge clk);
                    #1;
                    return;
                end
                if (inv_mode == 2 && b == 0 && d == 0) invalidate = 1'b1;
                @(negedge clk);
                chk("bus_req", 32'(mem_req), 32'd1);
                chk("bus_busy", 32'(busy), 32'd1);
                chk("bus_we", 32'(mem_we), 32'(is_wr));
                chk("bus_addr", 32'(mem_addr), is_wr ? 32'(a) : 32'({line, bb}));
                if (is_wr) begin
                    chk("bus_wstrb", 32'(mem_wstrb), 32'(wen));
                    chk("bus_wdata", mem_wdata, wd);
                end
                if (d == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = is_wr ? $urandom : mem_val({line, bb});
                end
                @(posedge clk);
                #1;
                mem_ack    = 1'b0;
                invalidate = 1'b0;
            end
        end
        if (is_wr) begin
            nv = mem_val(a);
            for (int k = 0; k < 4; k++) if (wen[k]) nv[8*k +: 8] = wd[8*k +: 8];
            mem_m[a] = nv;
        end
        @(negedge clk);
        chk("resp_busy", 32'(busy), 32'd0);
        chk("resp_req", 32'(mem_req), 32'd0);
        if (!is_wr) begin
            chk("resp_data", core_rdata, mem_val(a));
            last_rd     = core_rdata;
            m_vld[idx]  = 1'b1;
            m_line[idx] = line;
        end
        if (inv_mode == 2) clear_model();
        @(posedge clk);
        #1;
        core_req = 1'b0;
    endtask

    initial begin
        bit [29:0] ra;
        bit [3:0]  rw;
        int        im;
        rst_n      = 1'b0;
        core_req   = 1'b0;
        core_addr  = 30'd0;
        core_wen   = 4'd0;
        core_wdata = 32'd0;
        invalidate = 1'b0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;
        last_rd    = 32'd0;
        clear_model();
        for (int i = 0; i < 4; i++) mem_m[30'h40 + 30'(i)] = 32'hA0 + 32'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        access(30'h41, 4'h0, 32'h0, 0, 0, 0);
        chk("refill_word1", last_rd, 32'hA1);
        access(30'h43, 4'h0, 32'h0, 0, 0, 0);
        chk("hit_word3", last_rd, 32'hA3);
        access(30'h40, 4'hF, 32'h11223344, 0, 0, 0);
        access(30'h40, 4'b0011, 32'hDEADBEEF, 1, 0, 0);
        access(30'h40, 4'h0, 32'h0, 0, 0, 0);
        chk("store_merge", last_rd, 32'h1122BEEF);
        access(30'h800, 4'hF, 32'h12345678, 0, 0, 0);
        access(30'h800, 4'h0, 32'h0, 0, 0, 0);
        chk("write_miss_mem", last_rd, 32'h12345678);
        access(30'h40 + 30'(LINES * 4), 4'h0, 32'h0, 3, 0, 0);
        access(30'h40, 4'h0, 32'h0, 3, 0, 0);
        access(30'h44, 4'b1100, 32'hCAFEF00D, 3, 0, 0);
        access(30'h50, 4'h0, 32'h0, 0, 0, 2);
        access(30'h50, 4'h0, 32'h0, 0, 0, 0);
        access(30'h60, 4'h0, 32'h0, 1, 2, 0);
        access(30'h60, 4'h0, 32'h0, 0, 0, 0);
        access(30'h61, 4'h0, 32'h0, 0, 1, 0);
        access(30'h61, 4'h0, 32'h0, 0, 1, 0);
        access(30'h62, 4'h0, 32'h0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            ra = 30'($urandom_range(0, 3) * 256 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            im = $urandom_range(0, 11);
            im = (im == 0) ? 1 : ((im == 1) ? 2 : 0);
            access(ra, rw, $urandom, $urandom_range(0, 2), im,
                   ($urandom_range(0, 19) == 0 && rw == 4'h0) ? $urandom_range(1, 3) : 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
